// File: rtl/itof_if.sv
// Operand/result handshake bundle for the integer-to-float converter.
// The master modport is the upstream/downstream side; slave is the converter.
interface itof_if;
  logic        valid_in;
  logic        ready_out;
  logic        valid_out;
  logic        ready_in;
  logic [4:0]  op;
  logic [2:0]  rm;
  logic [31:0] int_in;
  logic [31:0] float_out;
  logic        IE;

  modport master (
    output valid_in, op, rm, int_in, ready_in,
    input  ready_out, valid_out, float_out, IE
  );

  modport slave (
    input  valid_in, op, rm, int_in, ready_in,
    output ready_out, valid_out, float_out, IE
  );
endinterface

// File: rtl/itof_converter.sv
// Two-stage int32 (signed or unsigned) to binary32 converter with
// valid/ready handshake on both sides; only the inexact flag can be raised.
module itof_converter (
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  itof_if.slave bus
);
  localparam logic [4:0] FPU_OP_CVTIF = 5'd10;
  localparam logic [4:0] FPU_OP_CVTUF = 5'd11;

  localparam logic [2:0] FPU_RM_RTZ = 3'd1;
  localparam logic [2:0] FPU_RM_RDN = 3'd2;
  localparam logic [2:0] FPU_RM_RUP = 3'd3;
  localparam logic [2:0] FPU_RM_RMM = 3'd4;

  logic        s1_valid_reg;
  logic        s1_sign_reg;
  logic [31:0] s1_mag_reg;
  logic [2:0]  s1_rm_reg;
  logic        s1_zero_reg;

  logic        valid_out_reg;
  logic [31:0] float_out_reg;
  logic        ie_reg;

  logic        en1;
  logic        en2;
  logic        op_ok;
  logic        accept;
  logic        in_sign;
  logic [31:0] in_mag;

  assign en2     = !valid_out_reg || bus.ready_in;
  assign en1     = !s1_valid_reg || en2;
  assign op_ok   = (bus.op == FPU_OP_CVTIF) || (bus.op == FPU_OP_CVTUF);
  assign accept  = bus.valid_in && en1 && op_ok;
  assign in_sign = (bus.op == FPU_OP_CVTIF) && bus.int_in[31];
  assign in_mag  = in_sign ? (32'd0 - bus.int_in) : bus.int_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_mag_reg   <= 32'd0;
      s1_rm_reg    <= 3'd0;
      s1_zero_reg  <= 1'b0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_mag_reg   <= 32'd0;
      s1_rm_reg    <= 3'd0;
      s1_zero_reg  <= 1'b0;
    end else if (en1) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_sign_reg <= in_sign;
        s1_mag_reg  <= in_mag;
        s1_rm_reg   <= bus.rm;
        s1_zero_reg <= (bus.int_in == 32'd0);
      end
    end
  end

  logic [4:0]  lzc;
  logic [31:0] norm;
  logic        rnd_bit;
  logic        sticky;
  logic        inc;
  logic [7:0]  exp_biased;
  logic [30:0] mag_sum;
  logic [31:0] res_float;
  logic        res_ie;

  // The last assignment wins, so lzc reflects the highest set bit.
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag_reg[i]) lzc = 5'(31 - i);
    end
  end

  assign norm    = s1_mag_reg << lzc;
  assign rnd_bit = norm[7];
  assign sticky  = |norm[6:0];
  // norm[31] is 1 for every nonzero operand, so this is 158 - lzc.
  assign exp_biased = 8'd157 + {7'd0, norm[31]} - {3'd0, lzc};

  always_comb begin
    case (s1_rm_reg)
      FPU_RM_RTZ: inc = 1'b0;
      FPU_RM_RDN: inc = s1_sign_reg && (rnd_bit || sticky);
      FPU_RM_RUP: inc = !s1_sign_reg && (rnd_bit || sticky);
      FPU_RM_RMM: inc = rnd_bit;
      default:    inc = rnd_bit && (sticky || norm[8]);
    endcase
  end

  // A fraction carry-out ripples into the exponent and leaves fraction 0.
  assign mag_sum   = {exp_biased, norm[30:8]} + {30'd0, inc};
  assign res_float = s1_zero_reg ? 32'd0 : {s1_sign_reg, mag_sum};
  assign res_ie    = !s1_zero_reg && (rnd_bit || sticky);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out_reg <= 1'b0;
      float_out_reg <= 32'd0;
      ie_reg        <= 1'b0;
    end else if (flush) begin
      valid_out_reg <= 1'b0;
      float_out_reg <= 32'd0;
      ie_reg        <= 1'b0;
    end else if (en2) begin
      valid_out_reg <= s1_valid_reg;
      float_out_reg <= s1_valid_reg ? res_float : 32'd0;
      ie_reg        <= s1_valid_reg ? res_ie : 1'b0;
    end
  end

  assign bus.ready_out = en1;
  assign bus.valid_out = valid_out_reg;
  assign bus.float_out = float_out_reg;
  assign bus.IE        = ie_reg;
endmodule

// File: tb/tb_itof_converter.sv
// Scoreboard bench for itof_converter: expected results are queued at
// accept time and compared by a monitor when the converter delivers them.
module tb_itof_converter;
  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_CVTIF = 5'd10;
  localparam logic [4:0] OP_CVTUF = 5'd11;
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  logic clk;
  logic reset;
  logic flush;
  itof_if bus ();

  itof_converter dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];
  bit chk_en = 0;
  bit rand_rdy = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.ready_in = 1'($urandom_range(0, 1));
    end
  end

  // Independent reference: truncate by right shift, round on the remainder.
  function automatic logic [32:0] model(input logic cvtif, input logic [2:0] r,
                                        input logic [31:0] x);
    logic        s;
    logic [31:0] m;
    logic [63:0] sig, rem, half;
    logic        inc;
    int          p, sh;
    s = cvtif && x[31];
    m = s ? (32'd0 - x) : x;
    if (m == 32'd0) return 33'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    if (p <= 23) begin
      sig = {32'd0, m} << (23 - p);
      rem = 64'd0;
      half = 64'd1;
    end else begin
      sh = p - 23;
      sig = {32'd0, m} >> sh;
      rem = {32'd0, m} & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
    end
    case (r)
      RM_RTZ: inc = 1'b0;
      RM_RDN: inc = s && (rem != 0);
      RM_RUP: inc = !s && (rem != 0);
      RM_RMM: inc = (rem != 0) && (rem >= half);
      default: inc = (rem > half) || ((rem == half) && (rem != 0) && sig[0]);
    endcase
    sig = sig + {63'd0, inc};
    if (sig[24]) begin
      sig = sig >> 1;
      p = p + 1;
    end
    return {rem != 0, s, 8'(p + 127), sig[22:0]};
  endfunction

  always @(negedge clk) begin
    int occ;
    logic [32:0] e;
    if (reset && !flush && chk_en) begin
      occ = exp_q.size();
      total++;
      if (bus.ready_out !== !(occ == 2 && !bus.ready_in)) begin
        bad++;
        $display("FAIL ready_out: got %b want %b (occupancy %0d ready_in %b)",
                 bus.ready_out, !(occ == 2 && !bus.ready_in), occ, bus.ready_in);
      end
      if (bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
        total++;
        if (occ == 0) begin
          bad++;
          $display("FAIL unexpected_result: got %h ie=%b, want no output",
                   bus.float_out, bus.IE);
        end else begin
          e = exp_q.pop_front();
          if ({bus.IE, bus.float_out} !== e) begin
            bad++;
            $display("FAIL result: got %h ie=%b want %h ie=%b",
                     bus.float_out, bus.IE, e[31:0], e[32]);
          end else begin
            $display("result %h ie=%b ok", bus.float_out, bus.IE);
          end
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [4:0] o, input logic [2:0] r,
                      input logic [31:0] x, input logic [32:0] e);
    int waits = 0;
    bus.valid_in = 1'b1;
    bus.op = o;
    bus.rm = r;
    bus.int_in = x;
    forever begin
      @(negedge clk);
      if (bus.ready_out === 1'b1) begin
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        break;
      end
      waits++;
      if (waits > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: ready_out %b want 1 within 200 cycles", bus.ready_out);
        @(posedge clk);
        #1;
        break;
      end
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({bus.valid_out, bus.IE, bus.float_out} !== 34'd0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b ie=%b float=%h want 0/0/0",
               bus.valid_out, bus.IE, bus.float_out);
    end
    @(negedge clk);
    total++;
    if (bus.ready_out !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", bus.ready_out);
    end
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1;
  endtask

  task automatic test_directed();
    bus.ready_in = 1'b1;
    send(OP_CVTIF, RM_RNE, 32'h00000001, {1'b0, 32'h3F800000});
    send(OP_CVTIF, RM_RNE, 32'hFFFFFFFF, {1'b0, 32'hBF800000});
    send(OP_CVTIF, RM_RNE, 32'h80000000, {1'b0, 32'hCF000000});
    send(OP_CVTIF, RM_RDN, 32'h00000000, {1'b0, 32'h00000000});
    send(OP_CVTIF, RM_RNE, 32'h01000001, {1'b1, 32'h4B800000});
    send(OP_CVTIF, RM_RUP, 32'h01000001, {1'b1, 32'h4B800001});
    send(OP_CVTIF, RM_RDN, 32'hFEFFFFFF, {1'b1, 32'hCB800001});
    send(OP_CVTUF, RM_RTZ, 32'hFFFFFFFF, {1'b1, 32'h4F7FFFFF});
    send(OP_CVTUF, RM_RNE, 32'hFFFFFFFF, {1'b1, 32'h4F800000});
    send(OP_CVTIF, RM_RMM, 32'h01000003, {1'b1, 32'h4B800002});
    send(OP_CVTUF, 3'd6,   32'h01000003, {1'b1, 32'h4B800002});
    wait_drain();
  endtask

  task automatic test_bad_op();
    bus.ready_in = 1'b1;
    bus.valid_in = 1'b1;
    bus.op = OP_ADD;
    bus.rm = RM_RNE;
    bus.int_in = 32'h00000005;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.valid_out !== 1'b0) begin
        bad++;
        $display("FAIL bad_op_valid: cycle %0d valid_out %b want 0", i, bus.valid_out);
      end
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] x;
    logic [2:0]  r;
    logic        cv;
    rand_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      x  = $urandom;
      r  = 3'($urandom_range(0, 7));
      cv = 1'($urandom_range(0, 1));
      send(cv ? OP_CVTIF : OP_CVTUF, r, x, model(cv, r, x));
    end
    rand_rdy = 0;
    #1;
    bus.ready_in = 1'b1;
    wait_drain();
  endtask

  task automatic test_flush();
    chk_en = 0;
    bus.ready_in = 1'b0;
    send(OP_CVTIF, RM_RNE, 32'h00000007, 33'd0);
    send(OP_CVTIF, RM_RNE, 32'h00000009, 33'd0);
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b1 || bus.ready_out !== 1'b0) begin
      bad++;
      $display("FAIL flush_full: valid=%b ready_out=%b want 1/0", bus.valid_out, bus.ready_out);
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    total++;
    if ({bus.valid_out, bus.IE, bus.float_out} !== 34'd0 || bus.ready_out !== 1'b1) begin
      bad++;
      $display("FAIL flush_clear: valid=%b ie=%b float=%h ready=%b want 0/0/0/1",
               bus.valid_out, bus.IE, bus.float_out, bus.ready_out);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    total++;
    if (bus.valid_out !== 1'b0) begin
      bad++;
      $display("FAIL flush_stage1: valid_out %b want 0", bus.valid_out);
    end
    bus.ready_in = 1'b1;
    chk_en = 1;
  endtask

  task automatic test_async_reset();
    chk_en = 0;
    bus.ready_in = 1'b0;
    send(OP_CVTUF, RM_RNE, 32'h00001234, 33'd0);
    send(OP_CVTUF, RM_RNE, 32'h00005678, 33'd0);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.valid_out, bus.IE, bus.float_out} !== 34'd0 || bus.ready_out !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: valid=%b ie=%b float=%h ready=%b want 0/0/0/1",
               bus.valid_out, bus.IE, bus.float_out, bus.ready_out);
    end
    exp_q.delete();
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.ready_in = 1'b1;
    chk_en = 1;
    @(posedge clk);
    #1;
    send(OP_CVTIF, RM_RUP, 32'h01000001, {1'b1, 32'h4B800001});
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: valid_out %b want 0 one cycle after accept", bus.valid_out);
    end
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b1 || bus.float_out !== 32'h4B800001) begin
      bad++;
      $display("FAIL latency_result: valid=%b float=%h want 1/4b800001",
               bus.valid_out, bus.float_out);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    bus.op = OP_ADD;
    bus.rm = RM_RNE;
    bus.int_in = 32'd0;
    test_reset();
    test_directed();
    test_bad_op();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
